// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path.
// Contents: opcode encoding, flag bit positions, controller state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'b0000,
    SUB   = 4'b0001,
    AND   = 4'b0010,
    OR    = 4'b0011,
    XOR   = 4'b0100,
    INC   = 4'b0101,
    PASSA = 4'b0110,
    PASSB = 4'b0111,
    LDI   = 4'b1000
  } opcode_e;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// General register file for the issue controller.
// Ports: clk/rst (async active-high, clears all registers), two
// combinational read ports (raddr_a/rdata_a, raddr_b/rdata_b) and one
// synchronous write port (we, waddr, wdata).
module alu_regfile #(
  parameter int BW   = 16,
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] raddr_a,
  input  logic [RW-1:0] raddr_b,
  output logic [BW-1:0] rdata_a,
  output logic [BW-1:0] rdata_b,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [BW-1:0] wdata
);

  logic [BW-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Instruction-issue controller driving an external combinational ALU.
// Ports: clk/rst (async active-high); instr_valid/instr_ready/instr
// instruction handshake {opcode, rd, ra, rb}; res_valid/res_ready/
// res_data/res_flags result handshake; alu_opcode/alu_in_a/alu_in_b to
// the ALU, alu_out/alu_flags from it; status_flags sticky last flags.
//
// state | meaning
// IDLE  | ready for an instruction; operands sampled on acceptance
// ISSUE | ALU evaluating registered operands; result captured at exit
// RESP  | result presented until consumer takes it
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter  int BW   = 16,
  parameter  int NREG = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [4+3*RW-1:0] instr,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [BW-1:0]   res_data,
  output logic [2:0]      res_flags,
  output logic [3:0]      alu_opcode,
  output logic [BW-1:0]   alu_in_a,
  output logic [BW-1:0]   alu_in_b,
  input  logic [BW-1:0]   alu_out,
  input  logic [2:0]      alu_flags,
  output logic [2:0]      status_flags
);

  state_e state_q, state_d;

  logic [3:0]      f_op;
  logic [RW-1:0]   f_rd, f_ra, f_rb;
  logic [RW-1:0]   rd_q;
  logic [2*RW-1:0] imm_q;
  logic [BW-1:0]   rdata_a, rdata_b;
  logic            accept;
  logic            is_ldi;
  logic            we;
  logic [BW-1:0]   imm;
  logic [BW-1:0]   wb_data;
  logic [2:0]      wb_flags;

  assign f_op = instr[3*RW+3 -: 4];
  assign f_rd = instr[3*RW-1 -: RW];
  assign f_ra = instr[2*RW-1 -: RW];
  assign f_rb = instr[RW-1:0];

  // Read ports look at the incoming fields directly so operands are
  // captured at acceptance, ahead of any write-back to the same register.
  alu_regfile #(.BW(BW), .NREG(NREG), .RW(RW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (f_ra),
    .raddr_b (f_rb),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (we),
    .waddr   (rd_q),
    .wdata   (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // LDI bypasses the ALU: immediate is {ra, rb} zero-extended.
  always_comb begin
    imm                = '0;
    imm[2*RW-1:0]      = imm_q;
    is_ldi             = (alu_opcode == LDI);
    wb_data            = is_ldi ? imm : alu_out;
    wb_flags           = alu_flags;
    if (is_ldi) begin
      wb_flags            = 3'b000;
      wb_flags[FLAG_ZERO] = (imm == '0);
    end
    // Opcodes above LDI report a result but never touch the register file.
    we = (state_q == ISSUE) && (!alu_opcode[3] || is_ldi);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_opcode   <= '0;
      alu_in_a     <= '0;
      alu_in_b     <= '0;
      rd_q         <= '0;
      imm_q        <= '0;
      res_data     <= '0;
      res_flags    <= '0;
      status_flags <= '0;
    end else begin
      if (accept) begin
        alu_opcode <= f_op;
        alu_in_a   <= rdata_a;
        alu_in_b   <= rdata_b;
        rd_q       <= f_rd;
        imm_q      <= {f_ra, f_rb};
      end
      if (state_q == ISSUE) begin
        res_data     <= wb_data;
        res_flags    <= wb_flags;
        status_flags <= wb_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int BW = 16;
  localparam int RW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [12:0]     instr = '0;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [BW-1:0]   res_data;
  logic [2:0]      res_flags;
  logic [3:0]      alu_opcode;
  logic [BW-1:0]   alu_in_a, alu_in_b, alu_out;
  logic [2:0]      alu_flags;
  logic [2:0]      status_flags;

  alu_issue_ctrl #(.BW(BW), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .alu_opcode(alu_opcode), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_out(alu_out), .alu_flags(alu_flags), .status_flags(status_flags)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU sitting beside the controller.
  always_comb begin
    alu_out   = '0;
    alu_flags = '0;
    case (alu_opcode)
      4'b0000: alu_out = alu_in_a + alu_in_b;
      4'b0001: alu_out = alu_in_a - alu_in_b;
      4'b0010: alu_out = alu_in_a & alu_in_b;
      4'b0011: alu_out = alu_in_a | alu_in_b;
      4'b0100: alu_out = alu_in_a ^ alu_in_b;
      4'b0101: alu_out = alu_in_a + 16'd1;
      4'b0110: alu_out = alu_in_a;
      4'b0111: alu_out = alu_in_b;
      default: alu_out = '0;
    endcase
    alu_flags[FLAG_ZERO] = (alu_out == '0);
    alu_flags[FLAG_NEG]  = alu_out[BW-1];
    case (alu_opcode)
      4'b0000: alu_flags[FLAG_OVF] = (alu_in_a[BW-1] == alu_in_b[BW-1]) && (alu_out[BW-1] != alu_in_a[BW-1]);
      4'b0001: alu_flags[FLAG_OVF] = (alu_in_a[BW-1] != alu_in_b[BW-1]) && (alu_out[BW-1] != alu_in_a[BW-1]);
      4'b0101: alu_flags[FLAG_OVF] = (alu_in_a == 16'h7fff);
      default: alu_flags[FLAG_OVF] = 1'b0;
    endcase
  end

  typedef struct packed { logic [BW-1:0] data; logic [2:0] flags; } exp_t;
  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency on each rising res_valid, data/flags on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && !rv_prev) chk("latency", cyc + 1 - accept_cyc, 2);
      if (res_valid && res_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("res_data", {16'h0, res_data}, {16'h0, e.data});
          chk("res_flags", {29'h0, res_flags}, {29'h0, e.flags});
        end
      end
    end
    rv_prev = res_valid;
  end

  function automatic logic [12:0] mk(input logic [3:0] op, input int rd, input int ra, input int rb);
    return {op, 3'(rd), 3'(ra), 3'(rb)};
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic issue(input logic [3:0] op, input int rd, input int ra, input int rb,
                       input logic push, input logic [BW-1:0] ed, input logic [2:0] ef);
    int n = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!instr_ready) begin chk("ready_timeout", 1, 0); return; end
    instr_valid = 1'b1;
    instr       = mk(op, rd, ra, rb);
    @(posedge clk); #1;
    accept_cyc  = cyc;
    instr_valid = 1'b0;
    instr       = 'x;
    if (push) q.push_back({ed, ef});
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || !instr_ready) && n < 40) begin @(posedge clk); #1; n++; end
    if (q.size() != 0 || !instr_ready) chk("done_timeout", 1, 0);
  endtask

  task automatic run(input logic [3:0] op, input int rd, input int ra, input int rb,
                     input logic [BW-1:0] ed, input logic [2:0] ef);
    issue(op, rd, ra, rb, 1'b1, ed, ef);
    wait_done();
  endtask

  initial begin
    logic [BW-1:0] held;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_status", status_flags, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: immediates
    run(4'b1000, 1, 0, 5, 16'h0005, 3'b000);
    run(4'b1000, 2, 0, 3, 16'h0003, 3'b000);

    // 2: ADD r3 = r1 + r2, operand ports visible during ISSUE
    issue(4'b0000, 3, 1, 2, 1'b1, 16'h0008, 3'b000);
    chk("issue_opcode", alu_opcode, 0);
    chk("issue_in_a", alu_in_a, 5);
    chk("issue_in_b", alu_in_b, 3);
    wait_done();

    // 3: zero result, then self-operand ADD
    run(4'b0001, 4, 2, 2, 16'h0000, 3'b001);
    chk("status_after_sub", status_flags, 3'b001);
    run(4'b0000, 2, 2, 2, 16'h0006, 3'b000);
    run(4'b0110, 6, 3, 0, 16'h0008, 3'b000);
    chk("status_after_passa", status_flags, 3'b000);

    // 4: backpressure on ADD r3 = r1 + r2 (5 + 6)
    res_ready = 1'b0;
    issue(4'b0000, 3, 1, 2, 1'b1, 16'h000b, 3'b000);
    @(posedge clk); #1;
    held = res_data;
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'b1;
      instr       = mk(4'b1000, 0, 7, 7);
      @(posedge clk); #1;
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, held);
      chk("bp_instr_ready", instr_ready, 0);
    end
    chk("bp_held_value", held, 16'h000b);
    instr_valid = 1'b0;
    res_ready   = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", instr_ready, 1);
    chk("bp_release_valid", res_valid, 0);
    wait_done();
    run(4'b0110, 6, 0, 0, 16'h0000, 3'b001);

    // 5: async reset during ISSUE of XOR r5 = r1 ^ r2
    issue(4'b0100, 5, 1, 2, 1'b0, 16'h0, 3'b0);
    #2 rst = 1'b1;
    #1;
    chk("ar_instr_ready", instr_ready, 1);
    chk("ar_res_valid", res_valid, 0);
    chk("ar_alu_opcode", alu_opcode, 0);
    chk("ar_alu_in_a", alu_in_a, 0);
    chk("ar_alu_in_b", alu_in_b, 0);
    chk("ar_res_data", res_data, 0);
    chk("ar_status", status_flags, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run(4'b0110, 6, 5, 0, 16'h0000, 3'b001);

    // 6: unassigned opcode leaves rd untouched
    run(4'b1000, 7, 1, 1, 16'h0009, 3'b000);
    run(4'b1111, 7, 7, 7, 16'h0000, 3'b001);
    chk("status_after_op15", status_flags, 3'b001);
    run(4'b0110, 6, 7, 0, 16'h0009, 3'b000);

    // Extra: signed overflow flags pass through verbatim
    run(4'b1000, 1, 7, 7, 16'h003f, 3'b000);
    run(4'b0001, 2, 0, 1, 16'hffc1, 3'b010);
    run(4'b0101, 3, 2, 0, 16'hffc2, 3'b010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
